// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI NOR flash word reader.
// The frame is an 8-bit command, a 24-bit address and 32 data clocks.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         FRAME_BITS = 64;
  localparam int         CMD_BITS   = 8;
  localparam int         ADDR_BITS  = 24;
  localparam int         DATA_BITS  = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP,
    GAP
  } state_t;

  // Flash streams the lowest memory byte first; restore little-endian order.
  function automatic logic [DATA_BITS-1:0] bswap32(
    input logic [DATA_BITS-1:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_reader_sck.sv
// SPI mode-0 clock generator: CLK_DIV cycles low, then CLK_DIV cycles high.
// Strobes mark the system edge that will drive sck high or low.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic rise_en,
  output logic fall_en
);

  logic [7:0] phase_q, phase_d;
  logic       sck_q, sck_d;
  logic       last;

  assign last    = run && (phase_q == 8'(CLK_DIV - 1));
  assign rise_en = last && !sck_q;
  assign fall_en = last && sck_q;
  assign sck     = sck_q;

  always_comb begin
    phase_d = 8'd0;
    sck_d   = 1'b0;
    if (run) begin
      phase_d = last ? 8'd0 : phase_q + 8'd1;
      sck_d   = last ? !sck_q : sck_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= 8'd0;
      sck_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sck_q   <= sck_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Fetches one 32-bit word per request from a serial NOR flash (03h READ).
// Owns the transaction FSM, the command/address shifter and the rx shifter.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 sck,
  output logic                 ss,
  output logic                 mosi,
  input  logic                 miso
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_flash_reader: CLK_DIV must be 1..255");
  end
  if (GAP_CYC < 1) begin : g_bad_gap
    $error("spi_flash_reader: GAP_CYC must be >= 1");
  end

  localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 1) ? GAP_CYC - 2 : 0;

  state_t                  state_q, state_d;
  logic [6:0]              bit_q, bit_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [DATA_BITS-1:0]    rx_q, rx_d;
  logic [DATA_BITS-1:0]    rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    ready_q, ready_d;
  logic                    ss_q, ss_d;
  logic                    mosi_q, mosi_d;
  logic [FRAME_BITS-1:0]   frame;
  logic                    rise_en, fall_en;

  // Low address bits go out as zero so every fetch is word aligned.
  assign frame = {CMD_READ, req_addr & 24'hFF_FFFC, 32'h0};

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck (
    .clock   (clock),
    .reset   (reset),
    .run     (state_q == SHIFT),
    .sck     (sck),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    ss_d     = ss_q;
    mosi_d   = mosi_q;
    unique case (state_q)
      IDLE: begin
        ss_d   = 1'b1;
        mosi_d = 1'b0;
        if (req_valid && ready_q) begin
          tx_d    = frame;
          mosi_d  = frame[FRAME_BITS-1];
          ss_d    = 1'b0;
          bit_d   = 7'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Responder shifts on sck rise, so sample the pre-rise value.
        if (rise_en && bit_q >= 7'(CMD_BITS + ADDR_BITS)) begin
          rx_d = {rx_q[DATA_BITS-2:0], miso};
        end
        if (fall_en) begin
          if (bit_q == 7'(FRAME_BITS - 1)) begin
            state_d  = RESP;
            ss_d     = 1'b1;
            mosi_d   = 1'b0;
            rvalid_d = 1'b1;
            rdata_d  = bswap32(rx_q);
          end else begin
            bit_d  = bit_q + 7'd1;
            tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            mosi_d = tx_q[FRAME_BITS-2];
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          gap_d    = '0;
          state_d  = (GAP_CYC == 1) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bit_q    <= 7'd0;
      gap_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b0;
      ss_q     <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
      ss_q     <= ss_d;
      mosi_q   <= mosi_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_data  = rdata_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench: two readers (CLK_DIV=2 and CLK_DIV=1) against a
// behavioural 03h-READ flash responder that shifts on sck rise.
module tb_spi_flash_reader;

  localparam int T = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #(T / 2) clock = ~clock;

  logic        req_valid_a = 0, req_ready_a, resp_valid_a;
  logic        resp_ready_a = 1;
  logic [23:0] req_addr_a = 0;
  logic [31:0] resp_data_a;
  logic        sck_a, ss_a, mosi_a, miso_a;

  logic        req_valid_b = 0, req_ready_b, resp_valid_b;
  logic        resp_ready_b = 1;
  logic [23:0] req_addr_b = 0;
  logic [31:0] resp_data_b;
  logic        sck_b, ss_b, mosi_b, miso_b;

  spi_flash_reader #(.CLK_DIV(2), .GAP_CYC(4)) u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_addr(req_addr_a), .resp_valid(resp_valid_a),
    .resp_ready(resp_ready_a), .resp_data(resp_data_a),
    .sck(sck_a), .ss(ss_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_flash_reader #(.CLK_DIV(1), .GAP_CYC(4)) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .resp_valid(resp_valid_b),
    .resp_ready(resp_ready_b), .resp_data(resp_data_b),
    .sck(sck_b), .ss(ss_b), .mosi(mosi_b), .miso(miso_b)
  );

  // Flash contents as little-endian words; erased flash reads all ones.
  function automatic logic [31:0] word_at(input logic [23:0] a);
    case (a)
      24'h000000: return 32'h1122_3344;
      24'h000004: return 32'hDEAD_BEEF;
      24'h000008: return 32'hCAFE_F00D;
      24'h00000C: return 32'h0BAD_C0DE;
      24'h000010: return 32'h5A5A_A5A5;
      24'hFFFFFC: return 32'h0123_4567;
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic stream_bit(input logic [23:0] a, input int k);
    logic [31:0] w;
    w = word_at(a);
    return w[8 * (k / 8) + 7 - (k % 8)];
  endfunction

  int          cnt_a = 0, cnt_b = 0;
  logic [31:0] hdr_a = 0, hdr_b = 0;

  always @(posedge sck_a or posedge ss_a)
    if (ss_a) cnt_a <= 0;
    else begin
      cnt_a <= cnt_a + 1;
      if (cnt_a < 32) hdr_a <= {hdr_a[30:0], mosi_a};
    end

  always @(posedge sck_b or posedge ss_b)
    if (ss_b) cnt_b <= 0;
    else begin
      cnt_b <= cnt_b + 1;
      if (cnt_b < 32) hdr_b <= {hdr_b[30:0], mosi_b};
    end

  assign miso_a = (!ss_a && cnt_a >= 32 && cnt_a < 64) ?
                  stream_bit(hdr_a[23:0], cnt_a - 32) : 1'b0;
  assign miso_b = (!ss_b && cnt_b >= 32 && cnt_b < 64) ?
                  stream_bit(hdr_b[23:0], cnt_b - 32) : 1'b0;

  // Frame monitor for reader a: pulse count, phase lengths, ss-low time.
  time  t_sck_a = 0, t_ssf_a = 0, ss_low_a = 0, t_rv_a = 0;
  int   pulses_a = 0, bad_half_a = 0, mosi_bad_a = 0;
  logic ss_p_a = 1'b1, sck_p_a = 1'b0;

  always @(ss_a or sck_a) begin
    if (ss_p_a === 1'b1 && ss_a === 1'b0) begin
      pulses_a = 0; bad_half_a = 0; mosi_bad_a = 0;
      t_ssf_a = $time; t_sck_a = $time;
    end else if (ss_p_a === 1'b0 && ss_a === 1'b1) begin
      ss_low_a = $time - t_ssf_a;
    end
    if (!reset && sck_a !== sck_p_a) begin
      if ($time - t_sck_a != time'(2 * T)) bad_half_a++;
      t_sck_a = $time;
      if (sck_a === 1'b1) begin
        pulses_a++;
        if (cnt_a >= 32 && mosi_a !== 1'b0) mosi_bad_a++;
      end
    end
    ss_p_a = ss_a;
    sck_p_a = sck_a;
  end

  always @(posedge resp_valid_a) t_rv_a = $time;

  time         ssf_b[$], ssr_b[$];
  logic [31:0] rsp_b[$];
  logic        ss_p_b = 1'b1;

  always @(ss_b) begin
    if (!reset) begin
      if (ss_p_b === 1'b1 && ss_b === 1'b0) ssf_b.push_back($time);
      else if (ss_p_b === 1'b0 && ss_b === 1'b1) ssr_b.push_back($time);
    end
    ss_p_b = ss_b;
  end

  always @(negedge clock)
    if (resp_valid_b === 1'b1) rsp_b.push_back(resp_data_b);

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_a(input logic [23:0] addr, output logic [31:0] data,
                        output logic ok);
    int n;
    ok = 1'b0;
    data = '0;
    @(negedge clock);
    req_addr_a = addr;
    req_valid_a = 1'b1;
    n = 0;
    while (req_ready_a !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    req_valid_a = 1'b0;
    req_addr_a = 24'hABCDEF;
    n = 0;
    while (resp_valid_a !== 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    ok = resp_valid_a;
    data = resp_data_a;
  endtask

  initial begin
    #(T * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        ok;
    int          n, errs;
    time         t_h;

    repeat (3) @(negedge clock);
    check("rst_ss", ss_a, 1);
    check("rst_sck", sck_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_rvalid", resp_valid_a, 0);
    check("rst_rdata", resp_data_a, 0);
    check("rst_ready", req_ready_a, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", req_ready_a, 1);

    read_a(24'h000004, d, ok);
    check("r4_done", ok, 1);
    check("r4_data", d, 32'hDEADBEEF);
    check("r4_hdr", hdr_a, 32'h03000004);
    check("r4_latency", t_rv_a - t_ssf_a, 256 * T);
    check("r4_ss_low", ss_low_a, 256 * T);
    check("r4_pulses", pulses_a, 64);
    check("r4_half", bad_half_a, 0);
    check("r4_mosi_data0", mosi_bad_a, 0);

    read_a(24'h00000F, d, ok);
    check("rF_done", ok, 1);
    check("rF_data", d, 32'h0BADC0DE);
    check("rF_hdr", hdr_a, 32'h0300000C);

    @(negedge clock);
    resp_ready_a = 1'b0;
    read_a(24'h000008, d, ok);
    check("stall_done", ok, 1);
    check("stall_data", d, 32'hCAFEF00D);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (resp_valid_a !== 1'b1 || resp_data_a !== 32'hCAFEF00D ||
          ss_a !== 1'b1 || sck_a !== 1'b0 || req_ready_a !== 1'b0)
        errs++;
    end
    check("stall_hold", errs, 0);
    req_valid_a = 1'b1;
    req_addr_a = 24'h000000;
    resp_ready_a = 1'b1;
    t_h = $time + time'(T / 2);
    n = 0;
    while (ss_a !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("gap_accept_seen", ss_a, 0);
    check("gap_len", t_ssf_a - t_h, 4 * T);
    req_valid_a = 1'b0;
    n = 0;
    while (resp_valid_a !== 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("after_gap_data", resp_data_a, 32'h11223344);

    @(negedge clock);
    req_addr_a = 24'h000008;
    req_valid_a = 1'b1;
    n = 0;
    while (req_ready_a !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    req_valid_a = 1'b0;
    n = 0;
    while (pulses_a < 21 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("mid_reached", pulses_a >= 21, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ss", ss_a, 1);
    check("mid_rst_sck", sck_a, 0);
    check("mid_rst_rvalid", resp_valid_a, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (resp_valid_a !== 1'b0) errs++;
    end
    check("mid_no_resp", errs, 0);

    read_a(24'h000010, d, ok);
    check("r10_done", ok, 1);
    check("r10_data", d, 32'h5A5AA5A5);
    check("r10_hdr", hdr_a, 32'h03000010);

    read_a(24'hFFFFFC, d, ok);
    check("top_done", ok, 1);
    check("top_data", d, 32'h01234567);
    check("top_hdr", hdr_a, 32'h03FFFFFC);
    check("top_pulses", pulses_a, 64);
    check("top_half", bad_half_a, 0);

    @(negedge clock);
    req_addr_b = 24'h000000;
    req_valid_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (req_ready_b !== 1'b1 && n < 400) begin
        @(negedge clock);
        n++;
      end
      @(negedge clock);
      if (i < 2) req_addr_b = 24'(4 * (i + 1));
      else req_valid_b = 1'b0;
    end
    n = 0;
    while (rsp_b.size() < 3 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("b_count", rsp_b.size(), 3);
    if (rsp_b.size() >= 3 && ssf_b.size() >= 3 && ssr_b.size() >= 2) begin
      check("b_data0", rsp_b[0], 32'h11223344);
      check("b_data1", rsp_b[1], 32'hDEADBEEF);
      check("b_data2", rsp_b[2], 32'hCAFEF00D);
      check("b_period0", ssf_b[1] - ssf_b[0], 133 * T);
      check("b_period1", ssf_b[2] - ssf_b[1], 133 * T);
      check("b_gap0", (ssf_b[1] - ssr_b[0]) >= time'(4 * T), 1);
      check("b_gap1", (ssf_b[2] - ssr_b[1]) >= time'(4 * T), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
